// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 8N1 framing, LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err output.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    state_t          next;
    logic            rx_meta;
    logic            rs;
    logic            rs_d;
    logic [CW-1:0]   div_cnt;
    logic            tick;
    logic [SW-1:0]   s;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            bit_smp;
    logic            stop_smp;
    logic            good_par;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
    logic            par_smp;
`endif

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (rs_d && !rs) next = START;
            end
            START: begin
                if (tick && s == S_MID) next = rs ? IDLE : DATA;
            end
            DATA: begin
                if (tick && s == S_LAST && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    next = PARITY;
`else
                    next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && s == S_LAST) next = STOP;
            end
`endif
            STOP: begin
                if (tick && s == S_LAST) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        bit_smp  = tick && (s == S_LAST) && (state == DATA);
        stop_smp = tick && (s == S_LAST) && (state == STOP);
`ifdef UART_RX_PARITY_EN
        par_smp  = tick && (s == S_LAST) && (state == PARITY);
        good_par = ~(^{shreg, par_bit});
`else
        good_par = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rs         <= 1'b1;
            rs_d       <= 1'b1;
            div_cnt    <= '0;
            s          <= '0;
            idx        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
            rs_d    <= rs;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            // Sample counter restarts on every state change to realign to the bit grid
            if (next != state) begin
                s <= '0;
            end else if (tick) begin
                s <= (s == S_LAST) ? '0 : s + 1'b1;
            end
            if (state != DATA) begin
                idx <= '0;
            end else if (bit_smp) begin
                idx <= idx + 1'b1;
            end
            if (bit_smp) shreg <= {rs, shreg[7:1]};
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (stop_smp) begin
                data_out   <= shreg;
                data_valid <= rs && good_par;
                frame_err  <= !rs;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_smp) par_bit <= rs;
            parity_err <= stop_smp && !good_par;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a
// frame-level model (expected event queue built from the bits sent).
module tb_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int NPB = 1;
`else
    localparam int NPB = 0;
`endif
    localparam int LAT_NOM = 2 + (19 + 2 * NPB) * BIT / 2 + 1;

    typedef logic [10:0] ev_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_dv_cyc = 0;
    int   bad_excl = 0;
    int   bad_width = 0;
    logic dv_prev = 1'b0;
    logic fe_prev = 1'b0;
    ev_t  got_q[$];
    ev_t  exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid || frame_err || parity_err)
            got_q.push_back({data_valid, frame_err, parity_err, data_out});
        if (data_valid && (frame_err || parity_err)) bad_excl++;
        if ((data_valid && dv_prev) || (frame_err && fe_prev)) bad_width++;
        if (data_valid) last_dv_cyc = cyc;
        dv_prev = data_valid;
        fe_prev = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Model: a frame yields one event; valid needs good stop and parity
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit par_ok);
        logic pe;
        start_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        if (NPB != 0) hold((^d) ^ !par_ok, BIT);
        hold(stop_ok, BIT);
        pe = (NPB != 0) && !par_ok;
        exp_q.push_back({stop_ok && par_ok, !stop_ok, pe, d});
    endtask

    task automatic drain(input string tag);
        int  n;
        ev_t g;
        ev_t e;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 4 * BIT) begin
            @(negedge clk);
            n++;
        end
        repeat (BIT / 4) @(negedge clk);
        check({tag, "_n"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check(tag, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         gap;
        logic [7:0] d;
        logic [7:0] v;
        bit         sok;
        bit         pok;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_in_busy", busy, 0);
        check("rst_in_data", data_out, 8'h00);
        reset = 1'b0;
        hold(1'b1, 2 * BIT);
        check("rst_data", data_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_pulse", {data_valid, frame_err, parity_err}, 0);
        check("rst_events", got_q.size(), 0);

        send_frame(8'hA5, 1, 1);
        lat = last_dv_cyc - start_cyc;
        check("lat_ok", (lat >= LAT_NOM - 20) && (lat <= LAT_NOM + 20), 1);
        hold(1'b1, BIT);
        check("a5_busy", busy, 0);
        drain("a5");

        send_frame(8'h00, 1, 1);
        send_frame(8'hFF, 1, 1);
        hold(1'b1, BIT);
        drain("b2b");

        send_frame(8'h3C, 0, 1);
        hold(1'b0, 20 * BIT);
        check("brk_busy", busy, 0);
        hold(1'b1, BIT);
        send_frame(8'h11, 1, 1);
        hold(1'b1, BIT);
        drain("brk");

        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("gl_busy_hi", busy, 1);
        hold(1'b0, 20);
        hold(1'b1, BIT);
        check("gl_busy_lo", busy, 0);
        drain("glitch");

        v = 8'h55;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(v[i], BIT);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        hold(1'b1, 2 * BIT);
        send_frame(8'h81, 1, 1);
        hold(1'b1, BIT);
        drain("mid_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 0);
        hold(1'b1, BIT);
        drain("par");
`endif

        for (int k = 0; k < 16; k++) begin
            d   = 8'($urandom);
            sok = ($urandom_range(0, 7) != 0);
            pok = (NPB != 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
            send_frame(d, sok, pok);
            gap = sok ? $urandom_range(0, 1) : $urandom_range(1, 2);
            hold(1'b1, gap * BIT + $urandom_range(0, 30));
        end
        hold(1'b1, BIT);
        drain("rnd");

        check("dv_excl", bad_excl, 0);
        check("pulse_w", bad_width, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
